// File: rtl/ucode_pkg.sv
// Shared encodings and microword field layout for the microcode sequencer.
// Field positions are functions of the width parameters so every file agrees on the layout.
package ucode_pkg;

    typedef enum logic [1:0] {
        SEL_INC  = 2'b00,
        SEL_JMP  = 2'b01,
        SEL_BR   = 2'b10,
        SEL_DISP = 2'b11
    } next_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Microword layout, MSB first: next_sel[1:0] | wait | halt | cond_sel | target | ctrl
    function automatic int ctrl_width(int dw, int aw, int cw);
        return dw - 4 - cw - aw;
    endfunction

    function automatic int target_lsb(int dw, int aw, int cw);
        return ctrl_width(dw, aw, cw);
    endfunction

    function automatic int cond_lsb(int dw, int aw, int cw);
        return target_lsb(dw, aw, cw) + aw;
    endfunction

    function automatic int halt_bit(int dw, int aw, int cw);
        return cond_lsb(dw, aw, cw) + cw;
    endfunction

    function automatic int wait_bit(int dw, int aw, int cw);
        return halt_bit(dw, aw, cw) + 1;
    endfunction

    function automatic int sel_lsb(int dw, int aw, int cw);
        return wait_bit(dw, aw, cw) + 1;
    endfunction

endpackage

// File: rtl/ucode_next_addr.sv
// Combinational next-address mux for the sequencer: increment, jump, branch, dispatch.
// All sums wrap modulo 2^ADDR_WIDTH.
module ucode_next_addr
    import ucode_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int COND_WIDTH   = 3,
    parameter int OPCODE_WIDTH = 5
) (
    input  next_sel_e                    sel_i,
    input  logic [ADDR_WIDTH-1:0]        upc_i,
    input  logic [ADDR_WIDTH-1:0]        target_i,
    input  logic [COND_WIDTH-1:0]        cond_sel_i,
    input  logic [(2**COND_WIDTH)-1:0]   cond_i,
    input  logic [OPCODE_WIDTH-1:0]      opcode_i,
    output logic [ADDR_WIDTH-1:0]        next_addr_o
);

    logic [ADDR_WIDTH-1:0] inc_addr;
    logic [ADDR_WIDTH-1:0] disp_addr;

    assign inc_addr  = upc_i + ADDR_WIDTH'(1);
    assign disp_addr = target_i + ADDR_WIDTH'(opcode_i);

    always_comb begin
        next_addr_o = inc_addr;
        case (sel_i)
            SEL_INC:  next_addr_o = inc_addr;
            SEL_JMP:  next_addr_o = target_i;
            SEL_BR:   next_addr_o = cond_i[cond_sel_i] ? target_i : inc_addr;
            SEL_DISP: next_addr_o = disp_addr;
            default:  next_addr_o = inc_addr;
        endcase
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: drives the ROM address combinationally from the UIR and loads
// the returned microword every cycle, with BOOT/RUN/HALT control and wait-for-ack holds.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 24,
    parameter int COND_WIDTH   = 3,
    parameter int OPCODE_WIDTH = 5,
    parameter int RESET_ADDR   = 0
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    output logic [ADDR_WIDTH-1:0]                         rom_addr_o,
    input  logic [DATA_WIDTH-1:0]                         rom_data_i,
    input  logic [(2**COND_WIDTH)-1:0]                    cond_i,
    input  logic [OPCODE_WIDTH-1:0]                       opcode_i,
    input  logic                                          ack_i,
    input  logic                                          resume_i,
    output logic [DATA_WIDTH-4-COND_WIDTH-ADDR_WIDTH-1:0] ctrl_o,
    output logic [ADDR_WIDTH-1:0]                         upc_o,
    output logic                                          halted_o,
    output logic                                          step_o
);

    localparam int CTRL_W   = ctrl_width(DATA_WIDTH, ADDR_WIDTH, COND_WIDTH);
    localparam int TGT_LSB  = target_lsb(DATA_WIDTH, ADDR_WIDTH, COND_WIDTH);
    localparam int COND_LSB = cond_lsb(DATA_WIDTH, ADDR_WIDTH, COND_WIDTH);
    localparam int HALT_B   = halt_bit(DATA_WIDTH, ADDR_WIDTH, COND_WIDTH);
    localparam int WAIT_B   = wait_bit(DATA_WIDTH, ADDR_WIDTH, COND_WIDTH);
    localparam int SEL_LSB  = sel_lsb(DATA_WIDTH, ADDR_WIDTH, COND_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] RST_ADDR = ADDR_WIDTH'(RESET_ADDR);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   uir_q;
    logic [ADDR_WIDTH-1:0]   upc_q;
    logic                    halted_q;

    next_sel_e               uir_sel;
    logic                    uir_wait;
    logic                    uir_halt;
    logic [COND_WIDTH-1:0]   uir_cond_sel;
    logic [ADDR_WIDTH-1:0]   uir_target;
    logic [CTRL_W-1:0]       uir_ctrl;
    logic [ADDR_WIDTH-1:0]   next_addr;

    assign uir_sel      = next_sel_e'(uir_q[SEL_LSB +: 2]);
    assign uir_wait     = uir_q[WAIT_B];
    assign uir_halt     = uir_q[HALT_B];
    assign uir_cond_sel = uir_q[COND_LSB +: COND_WIDTH];
    assign uir_target   = uir_q[TGT_LSB +: ADDR_WIDTH];
    assign uir_ctrl     = uir_q[0 +: CTRL_W];

    ucode_next_addr #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .COND_WIDTH   (COND_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_next_addr (
        .sel_i       (uir_sel),
        .upc_i       (upc_q),
        .target_i    (uir_target),
        .cond_sel_i  (uir_cond_sel),
        .cond_i      (cond_i),
        .opcode_i    (opcode_i),
        .next_addr_o (next_addr)
    );

    // Holding at upc makes the ROM re-present the same word, so the UIR reload is a no-op.
    always_comb begin
        rom_addr_o = upc_q;
        step_o     = 1'b0;
        state_d    = state_q;
        case (state_q)
            ST_BOOT: begin
                rom_addr_o = RST_ADDR;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (uir_halt) begin
                    state_d = ST_HALT;
                end else if (!(uir_wait && !ack_i)) begin
                    rom_addr_o = next_addr;
                    step_o     = 1'b1;
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    rom_addr_o = next_addr;
                    step_o     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                rom_addr_o = RST_ADDR;
                state_d    = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_BOOT;
            upc_q    <= RST_ADDR;
            uir_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            upc_q    <= rom_addr_o;
            uir_q    <= rom_data_i;
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign ctrl_o   = (state_q == ST_RUN) ? uir_ctrl : '0;
    assign upc_o    = upc_q;
    assign halted_o = halted_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: directed microprograms plus random ROM images,
// compared against a cycle-level reference model of the sequencing rules.
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rom_addr_o;
    logic [23:0] rom_data_i;
    logic [7:0]  cond_i;
    logic [4:0]  opcode_i;
    logic        ack_i;
    logic        resume_i;
    logic [8:0]  ctrl_o;
    logic [7:0]  upc_o;
    logic        halted_o;
    logic        step_o;

    logic [23:0] mem [256];

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = BOOT, 1 = RUN, 2 = HALT
    int m_state;
    int m_upc;
    int e_addr, e_step, e_ctrl, e_halt;

    always #5 clk = ~clk;

    assign rom_data_i = mem[rom_addr_o];

    ucode_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .cond_i     (cond_i),
        .opcode_i   (opcode_i),
        .ack_i      (ack_i),
        .resume_i   (resume_i),
        .ctrl_o     (ctrl_o),
        .upc_o      (upc_o),
        .halted_o   (halted_o),
        .step_o     (step_o)
    );

    function automatic logic [23:0] mw(int sel, int wt, int ht, int cs, int tgt, int ctl);
        return 24'((sel << 22) | (wt << 21) | (ht << 20) | (cs << 17) | (tgt << 9) | ctl);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Where the word at upc would send the sequencer if it advances.
    function automatic int follow(int upc, logic [7:0] c, logic [4:0] op);
        logic [23:0] w;
        int sel, cs, tgt;
        w   = mem[upc];
        sel = int'(w[23:22]);
        cs  = int'(w[19:17]);
        tgt = int'(w[16:9]);
        case (sel)
            0:       return (upc + 1) % 256;
            1:       return tgt;
            2:       return c[cs] ? tgt : (upc + 1) % 256;
            default: return (tgt + int'(op)) % 256;
        endcase
    endfunction

    task automatic predict(input logic [7:0] c, input logic [4:0] op, input logic a, input logic r);
        logic [23:0] w;
        w = mem[m_upc];
        e_addr = m_upc;
        e_step = 0;
        e_ctrl = 0;
        e_halt = 0;
        if (m_state == 0) begin
            e_addr = 0;
        end else if (m_state == 1) begin
            e_ctrl = int'(w[8:0]);
            if (!w[20] && !(w[21] && !a)) begin
                e_addr = follow(m_upc, c, op);
                e_step = 1;
            end
        end else begin
            e_halt = 1;
            if (r) begin
                e_addr = follow(m_upc, c, op);
                e_step = 1;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic [7:0] c, input logic [4:0] op, input logic a, input logic r);
        logic [23:0] w;
        cond_i   = c;
        opcode_i = op;
        ack_i    = a;
        resume_i = r;
        predict(c, op, a, r);
        #1;
        chk("rom_addr", 32'(rom_addr_o), 32'(e_addr));
        chk("upc",      32'(upc_o),      32'(m_upc));
        chk("ctrl",     32'(ctrl_o),     32'(e_ctrl));
        chk("halted",   32'(halted_o),   32'(e_halt));
        chk("step",     32'(step_o),     32'(e_step));
        @(posedge clk);
        w = mem[m_upc];
        if (m_state == 0)             m_state = 1;
        else if (m_state == 1 && w[20]) m_state = 2;
        else if (m_state == 2 && r)   m_state = 1;
        m_upc = e_addr;
        @(negedge clk);
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        m_state = 0;
        m_upc   = 0;
        #1;
        chk("rst_rom_addr", 32'(rom_addr_o), 32'(0));
        chk("rst_ctrl",     32'(ctrl_o),     32'(0));
        chk("rst_halted",   32'(halted_o),   32'(0));
        chk("rst_step",     32'(step_o),     32'(0));
        chk("rst_upc",      32'(upc_o),      32'(0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 24'h0;
    endtask

    initial begin
        reset_n  = 1'b0;
        cond_i   = '0;
        opcode_i = '0;
        ack_i    = 1'b0;
        resume_i = 1'b0;
        clear_mem();

        // Program A: branches, dispatch, wrap
        assert_reset();
        mem[8'h00] = mw(1, 0, 0, 0, 8'h10, 9'h101);
        mem[8'h10] = mw(2, 0, 0, 3, 8'h40, 9'h0A5);
        mem[8'h40] = mw(1, 0, 0, 0, 8'h10, 9'h040);
        mem[8'h11] = mw(3, 0, 0, 0, 8'h80, 9'h011);
        mem[8'h85] = mw(3, 0, 0, 0, 8'hFE, 9'h085);
        mem[8'h01] = mw(1, 0, 0, 0, 8'hFF, 9'h001);
        mem[8'hFF] = mw(0, 0, 0, 0, 8'h00, 9'h1FF);
        release_reset();
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        chk("boot_upc", 32'(upc_o), 32'h00);
        chk("boot_ctrl", 32'(ctrl_o), 32'h101);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        cyc(8'h08, 5'd0, 1'b0, 1'b0);
        chk("br_taken", 32'(upc_o), 32'h40);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        chk("br_not_taken", 32'(upc_o), 32'h11);
        cyc(8'h00, 5'd5, 1'b0, 1'b0);
        chk("disp_80_5", 32'(upc_o), 32'h85);
        cyc(8'h00, 5'd3, 1'b0, 1'b0);
        chk("disp_wrap", 32'(upc_o), 32'h01);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        chk("inc_wrap", 32'(upc_o), 32'h00);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        #3;
        assert_reset();

        // Program B: wait for ack, then halt and resume
        clear_mem();
        mem[8'h00] = mw(1, 0, 0, 0, 8'h20, 9'h100);
        mem[8'h20] = mw(0, 1, 0, 0, 8'h00, 9'h120);
        mem[8'h21] = mw(1, 0, 1, 0, 8'h30, 9'h121);
        mem[8'h30] = mw(1, 0, 0, 0, 8'h30, 9'h130);
        release_reset();
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        chk("wait_enter", 32'(upc_o), 32'h20);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h00, 5'd0, 1'b0, 1'b0);
            chk("wait_hold_upc", 32'(upc_o), 32'h20);
            chk("wait_hold_ctrl", 32'(ctrl_o), 32'h120);
        end
        cyc(8'h00, 5'd0, 1'b1, 1'b0);
        chk("wait_advance", 32'(upc_o), 32'h21);
        chk("halt_word_ctrl", 32'(ctrl_o), 32'h121);
        cyc(8'h00, 5'd0, 1'b1, 1'b0);
        chk("halt_entered", 32'(halted_o), 32'h1);
        for (int i = 0; i < 4; i++) cyc(8'h00, 5'd0, 1'b1, 1'b0);
        chk("halt_ctrl_zero", 32'(ctrl_o), 32'h0);
        cyc(8'h00, 5'd0, 1'b0, 1'b1);
        chk("resume_upc", 32'(upc_o), 32'h30);
        chk("resume_halted", 32'(halted_o), 32'h0);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);

        // Reset in the middle of a wait hold
        #2;
        assert_reset();
        release_reset();
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        #3;
        assert_reset();
        release_reset();
        cyc(8'h00, 5'd0, 1'b0, 1'b0);
        chk("post_wait_reset_upc", 32'(upc_o), 32'h00);

        // Random ROM images and random inputs
        for (int round = 0; round < 4; round++) begin
            #2;
            assert_reset();
            for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
            release_reset();
            for (int n = 0; n < 250; n++) begin
                cyc(8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Microcode sequencer feeding the combinational microcode ROM.
- Drives the ROM address and registers the returned microword into a microinstruction register (UIR).
- Decodes the UIR sequencing field: increment, jump, conditional branch, opcode dispatch, wait-for-ack, halt.
- Emits the UIR control field to the datapath. Sits between the instruction decoder/flags and the ROM.

Parameters:
- ADDR_WIDTH, 8, ROM address width; micro-PC wraps mod 2^ADDR_WIDTH.
- DATA_WIDTH, 24, microword width (must equal ROM DATA_WIDTH).
- COND_WIDTH, 3, condition-select field width; cond_i is 2^COND_WIDTH bits.
- OPCODE_WIDTH, 5, dispatch opcode width (OPCODE_WIDTH <= ADDR_WIDTH).
- RESET_ADDR, 0, first microword fetched after reset.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rom_addr_o  out  ADDR_WIDTH  address to ROM; combinational next address.
- rom_data_i  in  DATA_WIDTH  microword from ROM, valid the same cycle.
- cond_i  in  2^COND_WIDTH  condition flags (ALU flags, interrupt, etc.).
- opcode_i  in  OPCODE_WIDTH  decoded opcode for dispatch.
- ack_i  in  1  memory/peripheral acknowledge for wait microwords.
- resume_i  in  1  leave HALT.
- ctrl_o  out  CTRL_WIDTH  UIR control field (CTRL_WIDTH = DATA_WIDTH-4-COND_WIDTH-ADDR_WIDTH, 9 at defaults).
- upc_o  out  ADDR_WIDTH  address of the word currently in the UIR.
- halted_o  out  1  high in HALT.
- step_o  out  1  one-cycle pulse when the UIR loads a new address.

Behaviour:
- Microword fields, MSB first:
  - next_sel[1:0]: 00 INC, 01 JMP, 10 BR, 11 DISP.
  - wait bit.
  - halt bit.
  - cond_sel[COND_WIDTH-1:0].
  - target[ADDR_WIDTH-1:0].
  - ctrl[CTRL_WIDTH-1:0].
- Next-address function (RUN state), computed from the UIR:
  - INC: upc+1.
  - JMP: target.
  - BR: cond_i[cond_sel] ? target : upc+1.
  - DISP: target + zero-extended opcode_i.
  - All sums truncate mod 2^ADDR_WIDTH.
- Each rising edge: uir <= rom_data_i, upc <= rom_addr_o. Zero-penalty branches; the path UIR -> next_addr -> ROM -> UIR is combinational.
- States BOOT, RUN, HALT:
  - BOOT: rom_addr_o=RESET_ADDR, ctrl_o=0, step_o=0. Next edge -> RUN with uir=mem[RESET_ADDR], upc=RESET_ADDR.
  - RUN, UIR halt=1: ctrl_o emitted this cycle; rom_addr_o=upc; next state HALT. Halt has priority over wait.
  - RUN, UIR wait=1 and ack_i=0: rom_addr_o=upc (UIR reloads the same word), ctrl_o held stable, step_o=0.
  - RUN, UIR wait=1 and ack_i=1: normal next address, step_o=1.
  - RUN, otherwise: normal next address, step_o=1.
  - HALT: ctrl_o=0, halted_o=1, rom_addr_o=upc. resume_i=1 applies the halt word's next_sel (wait ignored), step_o=1, -> RUN.
- Reset (async, any time, including mid-wait or HALT):
  - state=BOOT, upc=RESET_ADDR, uir=0.
  - ctrl_o=0, halted_o=0, step_o=0, rom_addr_o=RESET_ADDR.
- upc_o = upc register; step_o is combinational from state/UIR/ack_i.
- cond_i, opcode_i and ack_i are sampled only via the combinational next address at the edge; they must be stable before the edge.

Decomposition:
- Package ucode_pkg:
  - next_sel encodings.
  - state encoding.
  - field offset/width constants derived from the parameters.
- Sub-module ucode_next_addr: purely combinational next-address mux (INC/JMP/BR/DISP, wrap).
- The top holds the state machine, upc, UIR, wait/halt holds.

Test Plan:
- Reset: reset_n=0 mid-run -> rom_addr_o=0, ctrl_o=0, halted_o=0 immediately. Release -> first edge upc_o=0, ctrl_o=word0.ctrl.
- Wrap: INC word at 0xFF -> next upc_o=0x00, step_o=1.
- Branch: BR cond_sel=3, target=0x40, upc=0x10. cond_i=8'h08 -> upc 0x40; cond_i=8'h00 -> upc 0x11.
- Dispatch: target=0x80, opcode_i=5 -> upc 0x85. target=0xFE, opcode_i=3 -> upc 0x01.
- Wait: wait word at 0x20, ack_i low 3 cycles -> upc_o=0x20 and ctrl_o stable 4 cycles, step_o=0 for 3. Advances on the ack cycle edge. Reset asserted mid-wait -> BOOT.
- Halt: halt+JMP target=0x30 -> ctrl_o shown 1 cycle, then halted_o=1, ctrl_o=0 indefinitely. resume_i pulse -> upc 0x30, halted_o=0.
